// File: rtl/pipelined_adder.sv
// Segmented, pipelined ripple-carry adder: one SEG_W-bit slice per stage, whole-pipe stall.
// Optional feature macro ADDER_SUB_EN adds the iSUB port (computes X + ~Y + iCIN).
module pipelined_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG_W = 8
) (
  input  logic             iCLK,
  input  logic             iRSTn,
  input  logic [WIDTH-1:0] iX,
  input  logic [WIDTH-1:0] iY,
  input  logic             iCIN,
`ifdef ADDER_SUB_EN
  input  logic             iSUB,
`endif
  input  logic             iVALID,
  output logic             oREADY,
  output logic [WIDTH-1:0] oSUM,
  output logic             oCARRY,
  output logic             oOVF,
  output logic             oVALID,
  input  logic             iREADY
);

  localparam int unsigned STAGES = WIDTH / SEG_W;
  localparam int unsigned OPS_N  = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int unsigned LAST   = STAGES - 1;

  if (SEG_W == 0 || (WIDTH % SEG_W) != 0) begin : g_width_check
    $error("pipelined_adder: WIDTH (%0d) must be a non-zero multiple of SEG_W (%0d)", WIDTH, SEG_W);
  end

  // Stage registers; stage k holds result segments 0..k plus the operands still to be added
  logic             r_vld [STAGES];
  logic             r_cy  [STAGES];
  logic [WIDTH-1:0] r_sum [STAGES];
  logic [WIDTH-1:0] r_x   [OPS_N];
  logic [WIDTH-1:0] r_y   [OPS_N];
  logic             r_ovf;

  logic             w_adv;
  logic [WIDTH-1:0] w_y0;
  logic [WIDTH-1:0] w_xi     [STAGES];
  logic [WIDTH-1:0] w_yi     [STAGES];
  logic [WIDTH-1:0] w_si     [STAGES];
  logic             w_ci     [STAGES];
  logic             w_vi     [STAGES];
  logic [SEG_W:0]   w_seg    [STAGES];
  logic [WIDTH-1:0] w_sum_nx [STAGES];
  logic             w_ovf;

  // Single advance enable: the pipe moves only when the output slot is free or being taken
  assign w_adv  = !oVALID || iREADY;
  assign oREADY = w_adv;

`ifdef ADDER_SUB_EN
  // Inverting Y on entry lets the subtract select travel implicitly with the beat
  assign w_y0 = iSUB ? ~iY : iY;
`else
  assign w_y0 = iY;
`endif

  // Per-stage segment add; the final stage also derives signed overflow
  always_comb begin
    w_xi[0] = iX;
    w_yi[0] = w_y0;
    w_si[0] = '0;
    w_ci[0] = iCIN;
    w_vi[0] = iVALID;
    for (int k = 1; k < int'(STAGES); k++) begin
      w_xi[k] = r_x[k-1];
      w_yi[k] = r_y[k-1];
      w_si[k] = r_sum[k-1];
      w_ci[k] = r_cy[k-1];
      w_vi[k] = r_vld[k-1];
    end
    for (int k = 0; k < int'(STAGES); k++) begin
      w_seg[k] = (SEG_W+1)'(w_xi[k][k*SEG_W +: SEG_W])
               + (SEG_W+1)'(w_yi[k][k*SEG_W +: SEG_W])
               + (SEG_W+1)'(w_ci[k]);
      w_sum_nx[k] = w_si[k];
      w_sum_nx[k][k*SEG_W +: SEG_W] = w_seg[k][SEG_W-1:0];
    end
    // Carry into the MSB is recovered from the MSB sum bit: x ^ y ^ s
    w_ovf = (w_xi[LAST][WIDTH-1] ^ w_yi[LAST][WIDTH-1] ^ w_sum_nx[LAST][WIDTH-1])
          ^ w_seg[LAST][SEG_W];
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        r_vld[k] <= 1'b0;
        r_cy[k]  <= 1'b0;
        r_sum[k] <= '0;
      end
      for (int k = 0; k < int'(OPS_N); k++) begin
        r_x[k] <= '0;
        r_y[k] <= '0;
      end
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        r_vld[k] <= w_vi[k];
        r_cy[k]  <= w_seg[k][SEG_W];
        r_sum[k] <= w_sum_nx[k];
      end
      for (int k = 0; k < int'(STAGES) - 1; k++) begin
        r_x[k] <= w_xi[k];
        r_y[k] <= w_yi[k];
      end
      r_ovf <= w_ovf;
    end
  end

  assign oVALID = r_vld[LAST];
  assign oSUM   = r_sum[LAST];
  assign oCARRY = r_cy[LAST];
  assign oOVF   = r_ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=32, SEG_W=8) with a queue-based result model.
module tb_pipelined_adder;

  localparam int W  = 32;
  localparam int ST = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  iX = '0, iY = '0;
  logic          iCIN = 1'b0, iSUB = 1'b0, iVALID = 1'b0, iREADY = 1'b1;
  logic          oREADY, oCARRY, oOVF, oVALID;
  logic [W-1:0]  oSUM;

  int total = 0;
  int bad   = 0;

  pipelined_adder #(.WIDTH(W), .SEG_W(8)) dut (
    .iCLK(clk), .iRSTn(rst_n), .iX(iX), .iY(iY), .iCIN(iCIN),
`ifdef ADDER_SUB_EN
    .iSUB(iSUB),
`endif
    .iVALID(iVALID), .oREADY(oREADY), .oSUM(oSUM), .oCARRY(oCARRY),
    .oOVF(oOVF), .oVALID(oVALID), .iREADY(iREADY)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference result {ovf, carry, sum} from plain wide arithmetic
  function automatic logic [33:0] ref_add(input logic [31:0] x, input logic [31:0] y,
                                          input logic cin, input logic sub);
    logic [31:0] yy;
    logic [32:0] full;
    longint      sres;
    logic        ov;
    yy   = sub ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + {32'd0, cin};
    sres = longint'($signed(x)) + longint'($signed(yy)) + longint'(cin);
    ov   = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
    return {ov, full};
  endfunction

  // Model: each accepted beat is tagged with the advance count at acceptance; it is
  // presented once ST-1 further advances have happened and held until the next advance.
  typedef struct { int tag; logic [33:0] r; } beat_t;
  beat_t q[$];
  int    adv_cnt = 0;
  int    dut_out = 0;
  int    mdl_out = 0;
  bit    m_ev;

  function automatic bit exp_valid();
    return (q.size() > 0) && (q[0].tag == adv_cnt - (ST - 1));
  endfunction

  always @(negedge rst_n) begin
    q.delete();
    adv_cnt = 0;
  end

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      m_ev = exp_valid();
      if (oVALID === 1'b1 && iREADY) dut_out++;
      if (m_ev && iREADY) mdl_out++;
      if (!m_ev || iREADY) begin
        adv_cnt++;
        if (iVALID) q.push_back('{adv_cnt, ref_add(iX, iY, iCIN, iSUB)});
        while (q.size() > 0 && q[0].tag < adv_cnt - (ST - 1)) void'(q.pop_front());
      end
    end
  end

  // Every-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    bit    ev;
    beat_t b;
    if (rst_n === 1'b1) begin
      ev = exp_valid();
      chk("oREADY", {63'd0, oREADY}, {63'd0, (!ev || iREADY)});
      chk("oVALID", {63'd0, oVALID}, {63'd0, ev});
      if (ev) begin
        b = q[0];
        chk("oSUM",   {32'd0, oSUM},   {32'd0, b.r[31:0]});
        chk("oCARRY", {63'd0, oCARRY}, {63'd0, b.r[32]});
        chk("oOVF",   {63'd0, oOVF},   {63'd0, b.r[33]});
      end
    end
  end

  task automatic directed(input string nm, input logic [31:0] x, input logic [31:0] y,
                          input logic cin, input logic sub,
                          input logic [31:0] es, input logic ec, input logic eo);
    int lat;
    chk({nm, " model"}, {30'd0, ref_add(x, y, cin, sub)}, {30'd0, eo, ec, es});
    iX = x; iY = y; iCIN = cin; iSUB = sub; iVALID = 1'b1; iREADY = 1'b1;
    @(posedge clk); #1;
    iVALID = 1'b0; iSUB = 1'b0;
    lat = 0;
    while (oVALID !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), 64'(ST - 1));
    chk({nm, " sum"},   {32'd0, oSUM},   {32'd0, es});
    chk({nm, " carry"}, {63'd0, oCARRY}, {63'd0, ec});
    chk({nm, " ovf"},   {63'd0, oOVF},   {63'd0, eo});
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] corner [4];
    corner[0] = 32'hFFFF_FFFF; corner[1] = 32'h7FFF_FFFF;
    corner[2] = 32'h8000_0000; corner[3] = 32'h0000_0000;
    if ($urandom_range(0, 5) == 0) return corner[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  task automatic new_ops();
    iX = rnd_op(); iY = rnd_op(); iCIN = 1'($urandom_range(0, 1));
`ifdef ADDER_SUB_EN
    iSUB = 1'($urandom_range(0, 1));
`endif
  endtask

  initial begin
    int n, cyc, seen;
    bit acc;

    // Reset held for 3 clocks with a valid beat presented
    iVALID = 1'b1; iX = 32'hDEAD_BEEF; iY = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1;
    chk("reset oVALID", {63'd0, oVALID}, 64'd0);
    chk("reset oSUM",   {32'd0, oSUM},   64'd0);
    chk("reset oCARRY", {63'd0, oCARRY}, 64'd0);
    chk("reset oOVF",   {63'd0, oOVF},   64'd0);
    chk("reset oREADY", {63'd0, oREADY}, 64'd1);
    iVALID = 1'b0;
    rst_n  = 1'b1;
    @(posedge clk); #1;

    directed("carry chain", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    directed("full wrap",   32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    directed("signed ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
`ifdef ADDER_SUB_EN
    directed("subtract",    32'd5,         32'd7,         1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
`endif

    // Back-to-back streaming with iREADY toggling every 2 cycles
    n = 0; cyc = 0;
    new_ops();
    while (n < 8 && cyc < 200) begin
      iREADY = ((cyc / 2) % 2) == 0;
      iVALID = 1'b1;
      #1;
      acc = (oREADY === 1'b1);
      @(posedge clk); #1;
      if (acc) begin
        n++;
        new_ops();
      end
      cyc++;
    end
    chk("stream beats accepted", 64'(n), 64'd8);
    iVALID = 1'b0;
    for (int i = 0; i < 16; i++) begin
      iREADY = ((i / 2) % 2) == 0;
      @(posedge clk); #1;
    end

    // Random valid/ready traffic
    for (int i = 0; i < 400; i++) begin
      new_ops();
      iVALID = 1'($urandom_range(0, 1));
      iREADY = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    iVALID = 1'b0; iREADY = 1'b1;
    repeat (ST + 2) @(posedge clk);
    #1;

    // Reset with two beats in flight: nothing may emerge afterwards
    iSUB = 1'b0;
    iX = 32'h0000_1111; iY = 32'h0000_2222; iCIN = 1'b0; iVALID = 1'b1;
    @(posedge clk); #1;
    iX = 32'h0000_3333; iY = 32'h0000_4444;
    @(posedge clk); #1;
    iVALID = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("midreset oVALID", {63'd0, oVALID}, 64'd0);
    chk("midreset oSUM",   {32'd0, oSUM},   64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (oVALID !== 1'b0) seen++;
    end
    chk("no output after reset", 64'(seen), 64'd0);
    directed("after reset", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

    repeat (ST + 2) @(posedge clk);
    #1;
    chk("handoff count", 64'(dut_out), 64'(mdl_out));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
